sample_pacing_fifo: RTL and testbench
=====================================

SAMPLE_PACING_FIFO -- requirements
Module: sample_pacing_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning FIFO depth = 2**DEPTH_LOG2 16-bit entries.
REQ-002 SHALL have parameter RESET_SAMPLE, default 16'h2000, meaning the sample_out value after reset (mid-scale for 14 fractional bits).
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port data_in, input, 8, host byte; host holds it stable around data_part_in transitions.
REQ-006 SHALL have port data_part_in, input, 1, asynchronous host byte strobe; a fall delivers the low byte, a rise delivers the high byte.
REQ-007 SHALL have port enable, input, 1, permits pacing pops when high.
REQ-008 SHALL have port divider, input, 8, number of pulse_done strobes per sample, minus 1.
REQ-009 SHALL have port pulse_done, input, 1, one-cycle strobe from the modulator at each PWM pulse end.
REQ-010 SHALL have port clear_flags, input, 1, clears the sticky flags.
REQ-011 SHALL have port sample_out, output, 16, current sample fed to the modulator's u16 register.
REQ-012 SHALL have port sample_valid, output, 1, one-cycle strobe marking a new sample_out.
REQ-013 SHALL have port fifo_level, output, DEPTH_LOG2+1, number of occupied entries.
REQ-014 SHALL have port overrun, output, 1, sticky flag: a write was dropped because the FIFO was full.
REQ-015 SHALL have port underrun, output, 1, sticky flag: a pop was due while the FIFO was empty.

Function
REQ-016 SHALL pass data_part_in through a 3-bit shift register (bits 2, 1, 0; input enters bit 2), with data_part = bit 1 and last = bit 0.
REQ-017 SHALL latch data_in into a low-byte register at the edge where data_part=0 and last=1 (falling edge detected).
REQ-018 SHALL push {data_in, low_byte} at the edge where data_part=1 and last=0, i.e. on the third clk edge after data_part_in rises.
REQ-019 SHALL drop a push when the FIFO is full with no simultaneous pop, leave the contents unchanged and set overrun.
REQ-020 SHALL keep a pace counter pace_cnt (8 bits); on pulse_done with enable=1: if pace_cnt==0, reload it from divider and attempt a pop; otherwise decrement it.
REQ-021 SHALL on a pop with the FIFO non-empty load the head entry into sample_out at that edge and assert sample_valid for exactly the following cycle.
REQ-022 SHALL on a pop with the FIFO empty hold sample_out, keep sample_valid low and set underrun.
REQ-023 SHALL force pace_cnt to 0 and perform no pops while enable=0; pushes continue regardless of enable.
REQ-024 SHALL on a simultaneous push and pop treat the pop first: a full FIFO accepts the push, and the level is unchanged.
REQ-025 SHALL on a simultaneous push and pop into an empty FIFO flag underrun and store the pushed word, with no bypass to sample_out.
REQ-026 SHALL give priority to a flag-setting event over clear_flags in the same cycle.
REQ-027 SHALL implement the pointers as DEPTH_LOG2-bit counters that wrap modulo depth; fifo_level ranges 0..2**DEPTH_LOG2.
REQ-028 SHALL pick up a change of divider at the next reload only, not mid-count.

Reset
REQ-029 SHALL on reset set sample_out=RESET_SAMPLE, sample_valid=0, fifo_level=0, overrun=0, underrun=0, pace_cnt=0, the shift register to 3'b111 and the pointers to 0.
REQ-030 SHALL on reset mid-operation discard all FIFO contents and any half-received byte pair, with no spurious push after reset releases while data_part_in is high.

Verification
REQ-031 SHALL cover: after reset, sample_out==16'h2000, fifo_level==0 and both flags are 0.
REQ-032 SHALL cover: byte pair 0x34 then 0x12 with enable=1, divider=0 and one pulse_done -> sample_out==16'h1234 and sample_valid high for one cycle.
REQ-033 SHALL cover: divider=3 with 2 queued samples -> pops occur on the 1st and 5th pulse_done strobes, and the 9th strobe sets underrun.
REQ-034 SHALL cover: 9 writes with depth 8 and enable=0 -> fifo_level==8, overrun==1, and readback yields the first 8 values in order.
REQ-035 SHALL cover: a full FIFO with a push coincident with a pop -> fifo_level stays 8 and overrun stays 0.
REQ-036 SHALL cover: clear_flags in the same cycle as a new underrun -> underrun stays 1, and a later clear_flags-only cycle -> 0.

Source files
------------

// File: rtl/sample_pacing_fifo.sv
// sample_pacing_fifo
// Collects 16-bit samples from a host that delivers them as two bytes on an
// asynchronous strobe (fall = low byte, rise = high byte), queues them in a
// small FIFO, and releases one sample every (divider+1) modulator pulses.
// Sticky overrun/underrun flags report dropped writes and starved pops.
module sample_pacing_fifo #(
   parameter int          DEPTH_LOG2   = 3,
   parameter logic [15:0] RESET_SAMPLE = 16'h2000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            data_in,
   input  logic                  data_part_in,
   input  logic                  enable,
   input  logic [7:0]            divider,
   input  logic                  pulse_done,
   input  logic                  clear_flags,
   output logic [15:0]           sample_out,
   output logic                  sample_valid,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  overrun,
   output logic                  underrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LVL_W = DEPTH_LOG2 + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1'b1);

   // Strobe synchronizer: bit 2 is the raw input, bit 1 the synchronized
   // level, bit 0 the previous synchronized level. Reset to all-ones so a
   // host holding the strobe high across reset produces no edge.
   logic [2:0]            sync_q, sync_d;
   logic [7:0]            low_byte_q, low_byte_d;
   logic [15:0]           mem_q [DEPTH];
   logic [15:0]           mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [7:0]            pace_q, pace_d;
   logic [15:0]           sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  underrun_q, underrun_d;

   logic                  fall_s;
   logic                  push_s;
   logic                  pop_req_s;
   logic                  do_pop_s;
   logic                  do_push_s;
   logic                  empty_s;
   logic                  full_s;

   // Next-state logic: byte assembly, pacing, FIFO pointers/level, flags.
   always_comb begin
      sync_d     = {data_part_in, sync_q[2:1]};
      low_byte_d = low_byte_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      pace_d     = pace_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      overrun_d  = overrun_q;
      underrun_d = underrun_q;
      pop_req_s  = 1'b0;

      fall_s  = (sync_q[1] == 1'b0) && (sync_q[0] == 1'b1);
      push_s  = (sync_q[1] == 1'b1) && (sync_q[0] == 1'b0);
      empty_s = (level_q == {LVL_W{1'b0}});
      full_s  = (level_q == LVL_FULL);

      if (fall_s) begin
         low_byte_d = data_in;
      end else begin
         low_byte_d = low_byte_q;
      end

      // Pace counter: divider is sampled only at reload time.
      if (!enable) begin
         pace_d = 8'd0;
      end else if (pulse_done) begin
         if (pace_q == 8'd0) begin
            pace_d    = divider;
            pop_req_s = 1'b1;
         end else begin
            pace_d = pace_q - 8'd1;
         end
      end else begin
         pace_d = pace_q;
      end

      // The pop is resolved first, so a full FIFO can take a same-cycle push
      // and an empty FIFO never forwards a same-cycle push to sample_out.
      do_pop_s  = pop_req_s && !empty_s;
      do_push_s = push_s && (!full_s || do_pop_s);

      if (do_pop_s) begin
         sample_d = mem_q[rd_ptr_q];
         valid_d  = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         sample_d = sample_q;
         rd_ptr_d = rd_ptr_q;
      end

      if (do_push_s) begin
         mem_d[wr_ptr_q] = {data_in, low_byte_q};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      // A new flag event wins over a same-cycle clear.
      if (push_s && !do_push_s) begin
         overrun_d = 1'b1;
      end else if (clear_flags) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      if (pop_req_s && empty_s) begin
         underrun_d = 1'b1;
      end else if (clear_flags) begin
         underrun_d = 1'b0;
      end else begin
         underrun_d = underrun_q;
      end
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= 3'b111;
         low_byte_q <= 8'h00;
         wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
         rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
         level_q    <= {LVL_W{1'b0}};
         pace_q     <= 8'd0;
         sample_q   <= RESET_SAMPLE;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         low_byte_q <= low_byte_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         pace_q     <= pace_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
      end
   end

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign fifo_level   = level_q;
   assign overrun      = overrun_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_sample_pacing_fifo.sv
// Directed testbench for sample_pacing_fifo (default depth 8).
module tb_sample_pacing_fifo;

   logic        clk;
   logic        reset;
   logic [7:0]  data_in;
   logic        data_part_in;
   logic        enable;
   logic [7:0]  divider;
   logic        pulse_done;
   logic        clear_flags;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic [3:0]  fifo_level;
   logic        overrun;
   logic        underrun;

   int n_checks = 0;
   int n_fail   = 0;

   sample_pacing_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_part_in (data_part_in),
      .enable       (enable),
      .divider      (divider),
      .pulse_done   (pulse_done),
      .clear_flags  (clear_flags),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .fifo_level   (fifo_level),
      .overrun      (overrun),
      .underrun     (underrun)
   );

   // Free-running clock, rising edge active.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", tag, got, exp);
      end
   endtask

   // Deliver one 16-bit word; called and returns on a falling clk edge.
   // With pop_with set, a pulse_done strobe lands on the same edge as the push.
   task automatic send_word(input logic [15:0] w, input bit pop_with, output logic v_seen);
      v_seen       = 1'b0;
      data_in      = w[7:0];
      data_part_in = 1'b0;
      repeat (4) @(negedge clk);
      data_in      = w[15:8];
      data_part_in = 1'b1;
      if (pop_with) enable = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 2 && pop_with) pulse_done = 1'b1;
         if (i == 3) begin
            pulse_done = 1'b0;
            v_seen     = sample_valid;
         end
      end
   endtask

   // One pulse_done strobe; reports sample_valid the cycle after and the one after that.
   task automatic pulse(output logic v, output logic v_after);
      pulse_done = 1'b1;
      @(negedge clk);
      pulse_done = 1'b0;
      v = sample_valid;
      @(negedge clk);
      v_after = sample_valid;
   endtask

   logic        v, va;
   logic [15:0] exp_rb [8];

   initial begin
      reset        = 1'b1;
      data_in      = 8'h00;
      data_part_in = 1'b1;
      enable       = 1'b0;
      divider      = 8'd0;
      pulse_done   = 1'b0;
      clear_flags  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_sample", 32'(sample_out), 32'h2000);
      check("rst_level",  32'(fifo_level), 32'd0);
      check("rst_valid",  32'(sample_valid), 32'd0);
      check("rst_ovr",    32'(overrun), 32'd0);
      check("rst_udr",    32'(underrun), 32'd0);

      // Basic byte pair and single pop
      enable  = 1'b1;
      divider = 8'd0;
      send_word(16'h1234, 1'b0, v);
      check("basic_level", 32'(fifo_level), 32'd1);
      pulse(v, va);
      check("basic_valid",  32'(v), 32'd1);
      check("basic_sample", 32'(sample_out), 32'h1234);
      check("basic_valid_1cyc", 32'(va), 32'd0);
      check("basic_level0", 32'(fifo_level), 32'd0);

      // Pacing with divider=3: pops on strobes 1 and 5, underrun on 9
      divider = 8'd3;
      send_word(16'hA1A1, 1'b0, v);
      send_word(16'hB2B2, 1'b0, v);
      for (int s = 1; s <= 9; s++) begin
         pulse(v, va);
         check($sformatf("pace_valid_%0d", s), 32'(v), (s == 1 || s == 5) ? 32'd1 : 32'd0);
         check($sformatf("pace_sample_%0d", s), 32'(sample_out), (s < 5) ? 32'hA1A1 : 32'hB2B2);
         if (s == 8) check("pace_udr_before", 32'(underrun), 32'd0);
         if (s == 9) check("pace_udr_9th", 32'(underrun), 32'd1);
      end

      // Flag clearing and set-over-clear priority
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      check("clr_udr", 32'(underrun), 32'd0);
      divider = 8'd0;
      enable  = 1'b0;
      @(negedge clk);
      enable      = 1'b1;
      clear_flags = 1'b1;
      pulse_done  = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      pulse_done  = 1'b0;
      check("prio_udr", 32'(underrun), 32'd1);
      @(negedge clk);
      check("prio_udr_hold", 32'(underrun), 32'd1);
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      check("prio_udr_clr", 32'(underrun), 32'd0);

      // Fill with enable=0: nine writes, the ninth dropped
      enable = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send_word(16'h1000 + 16'(i), 1'b0, v);
         if (i == 7) begin
            check("fill_level8", 32'(fifo_level), 32'd8);
            check("fill_ovr_before", 32'(overrun), 32'd0);
         end
      end
      check("ovr_level", 32'(fifo_level), 32'd8);
      check("ovr_flag",  32'(overrun), 32'd1);
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      check("ovr_clr", 32'(overrun), 32'd0);

      // Full FIFO: push coincident with pop is accepted
      send_word(16'hBEEF, 1'b1, v);
      check("full_pp_valid",  32'(v), 32'd1);
      check("full_pp_sample", 32'(sample_out), 32'h1000);
      check("full_pp_level",  32'(fifo_level), 32'd8);
      check("full_pp_ovr",    32'(overrun), 32'd0);

      // Readback order, wrapping the pointers
      exp_rb = '{16'h1001, 16'h1002, 16'h1003, 16'h1004,
                 16'h1005, 16'h1006, 16'h1007, 16'hBEEF};
      for (int k = 0; k < 8; k++) begin
         pulse(v, va);
         check($sformatf("rb_valid_%0d", k), 32'(v), 32'd1);
         check($sformatf("rb_sample_%0d", k), 32'(sample_out), 32'(exp_rb[k]));
      end
      check("rb_level0", 32'(fifo_level), 32'd0);
      check("rb_udr",    32'(underrun), 32'd0);

      // Push coincident with pop into an empty FIFO: underrun, no bypass
      send_word(16'h5A5A, 1'b1, v);
      check("empty_pp_valid",  32'(v), 32'd0);
      check("empty_pp_sample", 32'(sample_out), 32'hBEEF);
      check("empty_pp_level",  32'(fifo_level), 32'd1);
      check("empty_pp_udr",    32'(underrun), 32'd1);

      // Reset mid-operation with a half-received pair and strobe high on release
      data_in      = 8'h77;
      data_part_in = 1'b0;
      repeat (4) @(negedge clk);
      data_part_in = 1'b1;
      data_in      = 8'h66;
      reset        = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_rst_level",  32'(fifo_level), 32'd0);
      check("mid_rst_sample", 32'(sample_out), 32'h2000);
      check("mid_rst_udr",    32'(underrun), 32'd0);
      enable  = 1'b1;
      divider = 8'd0;
      pulse(v, va);
      check("mid_rst_empty_valid", 32'(v), 32'd0);
      check("mid_rst_empty_udr",   32'(underrun), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
